// File: rtl/mmio_led_pwm.sv
// mmio_led_pwm: MMIO-mapped LED controller with per-LED PWM duty, enable mask and blink
module mmio_led_pwm #(
   parameter int          NUM_LEDS   = 24,
   parameter int          PWM_BITS   = 8,
   parameter int          BLINK_BITS = 24,
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0100
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   input  logic                mmio_read,
   input  logic                mmio_write,
   input  logic [31:0]         mmio_addr,
   input  logic [31:0]         mmio_write_data,
   output logic                mmio_work,
   output logic                mmio_done,
   output logic [31:0]         mmio_read_data,
   output logic [NUM_LEDS-1:0] leds_pin
);
   logic [PWM_BITS-1:0]   duty_shadow [NUM_LEDS];
   logic [PWM_BITS-1:0]   duty_active [NUM_LEDS];
   logic [NUM_LEDS-1:0]   enable;
   logic [NUM_LEDS-1:0]   blink;
   logic [BLINK_BITS-1:0] period;
   logic [BLINK_BITS-1:0] blink_cnt;
   logic [PWM_BITS-1:0]   pwm_cnt;
   logic                  blink_phase;
   logic [5:0]            offset;
   logic                  accept;
   logic                  wr_en;
   logic [31:0]           duty_rd;
   logic [31:0]           rd_val;
   logic                  unused_bits;

   assign mmio_work   = mmio_addr[31:8] == BASE_ADDR[31:8];
   assign offset      = mmio_addr[7:2];
   assign accept      = mmio_work & ~mmio_done;
   assign wr_en       = accept & mmio_write;
   assign unused_bits = ^{mmio_addr[1:0], mmio_write_data};

   // read mux: duty shadows, config registers and status; everything else reads 0
   always_comb begin
      duty_rd = '0;
      for (int i = 0; i < NUM_LEDS; i++)
         if (offset == 6'(i)) duty_rd = 32'(duty_shadow[i]);
      rd_val = offset <  6'h20 ? duty_rd :
               offset == 6'h20 ? 32'(enable) :
               offset == 6'h21 ? 32'(blink) :
               offset == 6'h22 ? 32'(period) :
               offset == 6'h23 ? (32'(pwm_cnt) << 16) | 32'(blink_phase) : '0;
   end

   // one-cycle acknowledge; a held request is accepted only while done is low
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         mmio_done      <= 1'b0;
         mmio_read_data <= '0;
      end else begin
         mmio_done      <= accept;
         mmio_read_data <= (accept & mmio_read) ? rd_val : '0;
      end
   end

   // software-visible configuration registers
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         enable <= '0;
         blink  <= '0;
         period <= '0;
         for (int i = 0; i < NUM_LEDS; i++) duty_shadow[i] <= '1;
      end else begin
         if (wr_en && offset == 6'h20) enable <= mmio_write_data[NUM_LEDS-1:0];
         if (wr_en && offset == 6'h21) blink  <= mmio_write_data[NUM_LEDS-1:0];
         if (wr_en && offset == 6'h22) period <= mmio_write_data[BLINK_BITS-1:0];
         for (int i = 0; i < NUM_LEDS; i++)
            if (wr_en && offset == 6'(i)) duty_shadow[i] <= mmio_write_data[PWM_BITS-1:0];
      end
   end

   // free-running PWM counter; duties go live only at wrap so a period is never torn
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         for (int i = 0; i < NUM_LEDS; i++) duty_active[i] <= '1;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (pwm_cnt == '1)
            for (int i = 0; i < NUM_LEDS; i++) duty_active[i] <= duty_shadow[i];
      end
   end

   // blink half-period timer, idle while period is zero
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (period == '0) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt >= period) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   // registered LED drive
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) leds_pin <= '0;
      else
         for (int i = 0; i < NUM_LEDS; i++)
            leds_pin[i] <= enable[i] & (pwm_cnt < duty_active[i]) & ~(blink[i] & blink_phase);
   end
endmodule

// File: tb/tb_mmio_led_pwm.sv
// tb_mmio_led_pwm: directed plus random bus traffic checked against a behavioural model
module tb_mmio_led_pwm;
   localparam int          NL   = 24;
   localparam logic [31:0] BASE = 32'hFFFF_0100;

   logic          sys_clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          mmio_read = 1'b0;
   logic          mmio_write = 1'b0;
   logic [31:0]   mmio_addr = '0;
   logic [31:0]   mmio_write_data = '0;
   logic          mmio_work;
   logic          mmio_done;
   logic [31:0]   mmio_read_data;
   logic [NL-1:0] leds_pin;
   int            errors = 0;
   int            checks = 0;

   always #5 sys_clk = ~sys_clk;

   mmio_led_pwm dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .mmio_read(mmio_read), .mmio_write(mmio_write),
      .mmio_addr(mmio_addr), .mmio_write_data(mmio_write_data), .mmio_work(mmio_work),
      .mmio_done(mmio_done), .mmio_read_data(mmio_read_data), .leds_pin(leds_pin)
   );

   // behavioural model: plain integers, pwm position is a counter modulo 256
   int unsigned   m_sh [NL];
   int unsigned   m_act [NL];
   int unsigned   m_en, m_bl, m_per, m_bcnt, m_pwm, m_rd, m_off;
   bit            m_ph, m_done, m_acc;
   logic [NL-1:0] m_leds;

   assign m_acc = (mmio_addr[31:8] == BASE[31:8]) && !m_done;
   assign m_off = {26'b0, mmio_addr[7:2]};

   function automatic int unsigned m_read(input int unsigned off);
      if (off < NL) return m_sh[off];
      if (off == 32) return m_en;
      if (off == 33) return m_bl;
      if (off == 34) return m_per;
      if (off == 35) return (m_pwm << 16) | 32'(m_ph);
      return 0;
   endfunction

   always @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NL; i++) begin
            m_sh[i]  <= 255;
            m_act[i] <= 255;
         end
         {m_en, m_bl, m_per, m_bcnt, m_pwm, m_rd} <= '0;
         m_ph   <= 1'b0;
         m_done <= 1'b0;
         m_leds <= '0;
      end else begin
         m_done <= m_acc;
         m_rd   <= (m_acc && mmio_read) ? m_read(m_off) : 0;
         if (m_acc && mmio_write) begin
            if (m_off < NL) m_sh[m_off] <= mmio_write_data & 32'hFF;
            else if (m_off == 32) m_en  <= mmio_write_data & 32'hFF_FFFF;
            else if (m_off == 33) m_bl  <= mmio_write_data & 32'hFF_FFFF;
            else if (m_off == 34) m_per <= mmio_write_data & 32'hFF_FFFF;
         end
         if (m_pwm == 255)
            for (int i = 0; i < NL; i++) m_act[i] <= m_sh[i];
         m_pwm <= (m_pwm + 1) % 256;
         if (m_per == 0) begin
            m_bcnt <= 0;
            m_ph   <= 1'b0;
         end else if (m_bcnt >= m_per) begin
            m_bcnt <= 0;
            m_ph   <= !m_ph;
         end else m_bcnt <= m_bcnt + 1;
         for (int i = 0; i < NL; i++)
            m_leds[i] <= m_en[i] && (m_pwm < m_act[i]) && !(m_bl[i] && m_ph);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge sys_clk);
      chk("work", 32'(mmio_work), 32'(mmio_addr[31:8] == BASE[31:8]));
      chk("done", 32'(mmio_done), 32'(m_done));
      chk("rdata", mmio_read_data, m_rd);
      chk("leds", 32'(leds_pin), 32'(m_leds));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic drive(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] d);
      mmio_read = rd;
      mmio_write = wr;
      mmio_addr = addr;
      mmio_write_data = d;
   endtask

   function automatic logic [31:0] reg_addr(input int off);
      return BASE | 32'(off << 2);
   endfunction

   task automatic xact(input bit rd, input bit wr, input int off, input logic [31:0] d,
                       output logic [31:0] q);
      drive(rd, wr, reg_addr(off), d);
      cyc();
      q = mmio_read_data;
      drive(0, 0, '0, '0);
      cyc();
   endtask

   initial begin
      logic [31:0] q, s0, s1, d;
      int hi3, hi0, off, n;
      bit rd, wr;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_done", 32'(mmio_done), 0);
      chk("rst_rdata", mmio_read_data, 0);
      chk("rst_leds", 32'(leds_pin), 0);
      idle(2);
      rst_n = 1'b1;
      xact(1, 0, 0, '0, q);
      chk("rd_duty0", q, 32'hFF);
      xact(1, 0, 32, '0, q);
      chk("rd_enable", q, 0);
      xact(0, 1, 32, 32'hFF_FFFF, q);
      xact(0, 1, 3, 32'h40, q);
      idle(260);
      hi3 = 0;
      hi0 = 0;
      for (int i = 0; i < 256; i++) begin
         cyc();
         hi3 += int'(leds_pin[3]);
         hi0 += int'(leds_pin[0]);
      end
      chk("led3_high", 32'(hi3), 64);
      chk("led0_high", 32'(hi0), 255);
      xact(0, 1, 34, 9, q);
      xact(0, 1, 33, 1, q);
      idle(5);
      drive(1, 0, reg_addr(35), '0);
      cyc();
      s0 = mmio_read_data;
      drive(0, 0, '0, '0);
      idle(9);
      drive(1, 0, reg_addr(35), '0);
      cyc();
      s1 = mmio_read_data;
      drive(0, 0, '0, '0);
      cyc();
      chk("blink_toggle", 32'(s0[0] ^ s1[0]), 1);
      for (int k = 0; k < 6; k++) begin
         chk("hold_done", 32'(mmio_done), 32'(k % 2));
         drive(0, 1, reg_addr(33), 32'h10 + 32'(k));
         cyc();
      end
      drive(0, 0, '0, '0);
      cyc();
      xact(1, 0, 33, '0, q);
      chk("hold_final", q, 32'h14);
      xact(0, 1, 24, 32'hAB, q);
      xact(0, 1, 48, 32'hFFFF_FFFF, q);
      xact(0, 1, 35, 32'hFFFF_FFFF, q);
      xact(1, 0, 24, '0, q);
      chk("rd_off18", q, 0);
      xact(1, 0, 48, '0, q);
      chk("rd_off30", q, 0);
      xact(1, 0, 35, '0, q);
      xact(0, 0, 5, 32'h55, q);
      drive(1, 1, 32'h1234_0080, 32'h77);
      idle(3);
      for (int t = 0; t < 300; t++) begin
         off = int'($urandom_range(0, 63));
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         d = $urandom;
         if (off == 34) d = $urandom_range(0, 15);
         if ($urandom_range(0, 9) == 0) drive(rd, wr, 32'h0000_1000 | 32'(off << 2), d);
         else drive(rd, wr, reg_addr(off), d);
         n = int'($urandom_range(1, 3));
         idle(n);
         if ($urandom_range(0, 1) == 1) begin
            drive(0, 0, '0, '0);
            cyc();
         end
      end
      drive(0, 0, '0, '0);
      idle(300);
      drive(0, 1, reg_addr(32), 32'h00AA_AAAA);
      rst_n = 1'b0;
      #1;
      chk("midrst_done", 32'(mmio_done), 0);
      chk("midrst_rdata", mmio_read_data, 0);
      chk("midrst_leds", 32'(leds_pin), 0);
      cyc();
      rst_n = 1'b1;
      drive(0, 0, '0, '0);
      cyc();
      xact(1, 0, 32, '0, q);
      chk("enable_after_rst", q, 0);
      idle(4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
